// File: rtl/legv8_pkg.sv
// Shared opcodes, ALU function codes and FSM/decode enums for the LEGv8 control unit.
package legv8_pkg;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [31:0] OP_HLT  = 32'hFFFF_FFFF;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_C = 2;
  localparam int STAT_V = 3;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;
  typedef enum logic [3:0] {C_ILL, C_R, C_I, C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ, C_HLT} iclass_t;
  typedef enum logic [2:0] {IMM_NONE, IMM_12, IMM_9, IMM_26, IMM_19} imm_kind_t;
endpackage

// File: rtl/legv8_decode.sv
// Pure combinational instruction decode: class, register fields, ALU function and immediate kind.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     cls,
  output imm_kind_t   imm_kind,
  output logic [4:0]  rd,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rt,
  output logic [4:0]  fs,
  output logic        sub
);
  assign rd = ir[4:0];
  assign rt = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];

  // Opcode fields of different widths never alias, so match order is irrelevant.
  always_comb begin
    cls      = C_ILL;
    imm_kind = IMM_NONE;
    fs       = FS_ADD;
    sub      = 1'b0;
    if (ir == OP_HLT) cls = C_HLT;
    else if (ir[31:24] == OP_CBZ)  begin cls = C_CBZ;  imm_kind = IMM_19; end
    else if (ir[31:24] == OP_CBNZ) begin cls = C_CBNZ; imm_kind = IMM_19; end
    else if (ir[31:26] == OP_B)    begin cls = C_B;    imm_kind = IMM_26; end
    else begin
      case (ir[31:21])
        OP_ADD:  cls = C_R;
        OP_SUB:  begin cls = C_R; fs = FS_SUB; sub = 1'b1; end
        OP_AND:  begin cls = C_R; fs = FS_AND; end
        OP_ORR:  begin cls = C_R; fs = FS_ORR; end
        OP_EOR:  begin cls = C_R; fs = FS_EOR; end
        OP_LDUR: begin cls = C_LDUR; imm_kind = IMM_9; end
        OP_STUR: begin cls = C_STUR; imm_kind = IMM_9; end
        default: begin
          if (ir[31:22] == OP_ADDI) begin
            cls = C_I; imm_kind = IMM_12;
          end else if (ir[31:22] == OP_SUBI) begin
            cls = C_I; imm_kind = IMM_12; fs = FS_SUB; sub = 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 control FSM: fetch handshake, decode, EXEC/MEM sequencing, PC strobes.
module control_unit_legv8
  import legv8_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  input  logic [AW-1:0] f,
  input  logic [3:0]    stat,
  output logic          instr_req,
  output logic [4:0]    DA,
  output logic [4:0]    SA,
  output logic [4:0]    SB,
  output logic [4:0]    FS,
  output logic          c_out,
  output logic          W_reg,
  output logic          W_ram,
  output logic          B_sel,
  output logic          B_en,
  output logic          alu_en,
  output logic          D_en,
  output logic          ram_en,
  output logic [DW-1:0] k,
  output logic [AW-1:0] addr,
  output logic          pc_inc,
  output logic          pc_load,
  output logic [DW-1:0] pc_off,
  output logic          halted,
  output logic          illegal
);
  state_t       state, state_nx;
  logic [31:0]  ir;
  iclass_t      cls;
  imm_kind_t    imm_kind;
  logic [4:0]   rd, rn, rm, rt, fs;
  logic         sub, ldst, taken;
  logic [DW-1:0] imm;
  logic         unused_stat;

  legv8_decode u_dec (
    .ir(ir), .cls(cls), .imm_kind(imm_kind),
    .rd(rd), .rn(rn), .rm(rm), .rt(rt), .fs(fs), .sub(sub)
  );

  assign ram_en      = 1'b0;
  assign unused_stat = ^stat[3:1];
  assign ldst        = (cls == C_LDUR) || (cls == C_STUR);
  assign taken       = (cls == C_CBZ) ? stat[STAT_Z] : !stat[STAT_Z];

  always_comb begin
    case (imm_kind)
      IMM_12:  imm = {{(DW-12){1'b0}}, ir[21:10]};
      IMM_9:   imm = {{(DW-9){ir[20]}}, ir[20:12]};
      IMM_26:  imm = {{(DW-28){ir[25]}}, ir[25:0], 2'b00};
      IMM_19:  imm = {{(DW-21){ir[23]}}, ir[23:5], 2'b00};
      default: imm = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      ir      <= '0;
      addr    <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && instr_valid) ir <= instr;
      if (state == EXEC && ldst) addr <= f;
      if (state == DECODE && (cls == C_ILL || cls == C_HLT)) halted <= 1'b1;
      if (state == DECODE && cls == C_ILL) illegal <= 1'b1;
    end
  end

  // Control word is gated by rst so a mid-instruction reset kills writes in the same cycle.
  always_comb begin
    state_nx  = state;
    instr_req = 1'b0;
    DA = '0; SA = '0; SB = '0; FS = FS_ADD;
    c_out = 1'b0; W_reg = 1'b0; W_ram = 1'b0; B_sel = 1'b0;
    B_en = 1'b0; alu_en = 1'b0; D_en = 1'b0;
    k = '0; pc_inc = 1'b0; pc_load = 1'b0; pc_off = '0;
    case (state)
      FETCH:  state_nx = instr_valid ? DECODE : FETCH;
      DECODE: state_nx = (cls == C_ILL || cls == C_HLT) ? HALT : EXEC;
      EXEC:   state_nx = ldst ? MEM : FETCH;
      MEM:    state_nx = FETCH;
      HALT:   state_nx = HALT;
      default: state_nx = FETCH;
    endcase
    if (rst) begin
      case (state)
        FETCH: instr_req = 1'b1;
        EXEC: begin
          case (cls)
            C_R, C_I: begin
              SA = rn; SB = rm; DA = rd; FS = fs; c_out = sub;
              B_sel = (cls == C_I); k = (cls == C_I) ? imm : '0;
              alu_en = 1'b1; W_reg = 1'b1; pc_inc = 1'b1;
            end
            C_LDUR, C_STUR: begin
              SA = rn; B_sel = 1'b1; k = imm;
            end
            C_B: begin
              pc_load = 1'b1; pc_off = imm;
            end
            C_CBZ, C_CBNZ: begin
              SA = rt; B_sel = 1'b1;
              pc_load = taken; pc_inc = !taken; pc_off = taken ? imm : '0;
            end
            default: ;
          endcase
        end
        MEM: begin
          SA = rn; pc_inc = 1'b1;
          if (cls == C_LDUR) begin
            DA = rt; D_en = 1'b1; W_reg = 1'b1;
          end else begin
            SB = rt; B_en = 1'b1; W_ram = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit_legv8.sv
// Scoreboarded bench: directed instructions push expected control words, a negedge monitor compares them.
module tb_control_unit_legv8;
  logic        clk = 1'b0;
  logic        rst, instr_valid;
  logic [31:0] instr;
  logic [7:0]  f, addr;
  logic [3:0]  stat;
  logic        instr_req, c_out, W_reg, W_ram, B_sel, B_en, alu_en, D_en, ram_en;
  logic        pc_inc, pc_load, halted, illegal;
  logic [4:0]  DA, SA, SB, FS;
  logic [63:0] k, pc_off;

  typedef struct packed {
    logic [4:0]  da, sa, sb, fs;
    logic        c_out, w_reg, w_ram, b_sel, b_en, alu_en, d_en, pc_inc, pc_load;
    logic [63:0] k, pc_off;
    logic [7:0]  addr;
  } ctl_t;
  typedef struct { string nm; ctl_t e; ctl_t m; } sb_t;

  sb_t  q[$];
  int   total = 0, bad = 0, cyc = 0;
  logic sb_on = 1'b0;

  control_unit_legv8 #(.DW(64), .AW(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .f(f), .stat(stat),
    .instr_req(instr_req), .DA(DA), .SA(SA), .SB(SB), .FS(FS), .c_out(c_out),
    .W_reg(W_reg), .W_ram(W_ram), .B_sel(B_sel), .B_en(B_en), .alu_en(alu_en), .D_en(D_en),
    .ram_en(ram_en), .k(k), .addr(addr), .pc_inc(pc_inc), .pc_load(pc_load), .pc_off(pc_off),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: bus/strobe invariants every cycle, scoreboard pop on every PC strobe.
  always @(negedge clk) begin
    ctl_t a;
    sb_t  s;
    if (rst) begin
      total++;
      if (!$onehot0({B_en, alu_en, D_en}) || (pc_inc && pc_load) || (W_reg && W_ram) || ram_en) begin
        bad++;
        $display("FAIL invariant act=B_en%0b alu_en%0b D_en%0b inc%0b load%0b wreg%0b wram%0b ram_en%0b",
                 B_en, alu_en, D_en, pc_inc, pc_load, W_reg, W_ram, ram_en);
      end
    end
    if (sb_on && (pc_inc || pc_load)) begin
      a = '{DA, SA, SB, FS, c_out, W_reg, W_ram, B_sel, B_en, alu_en, D_en, pc_inc, pc_load, k, pc_off, addr};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe act=%h exp=none", a);
      end else begin
        s = q.pop_front();
        if (((a ^ s.e) & s.m) != '0) begin
          bad++;
          $display("FAIL %s act=%h exp=%h care=%h", s.nm, a, s.e, s.m);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic exp_alu(input string nm, input logic [4:0] da, sa, sb, fs, input logic c, imm,
                         input logic [63:0] kv);
    ctl_t e, m;
    e = '0; m = '1;
    e.da = da; e.sa = sa; e.sb = sb; e.fs = fs; e.c_out = c; e.b_sel = imm; e.k = kv;
    e.w_reg = 1'b1; e.alu_en = 1'b1; e.pc_inc = 1'b1;
    if (imm) m.sb = '0; else m.k = '0;
    m.addr = '0; m.pc_off = '0;
    q.push_back('{nm, e, m});
  endtask

  task automatic exp_mem(input string nm, input logic ld, input logic [4:0] rt, input logic [7:0] a);
    ctl_t e, m;
    e = '0; m = '1;
    e.addr = a; e.pc_inc = 1'b1;
    if (ld) begin e.da = rt; e.d_en = 1'b1; e.w_reg = 1'b1; m.sb = '0; m.b_sel = 1'b0; end
    else begin e.sb = rt; e.b_en = 1'b1; e.w_ram = 1'b1; m.da = '0; end
    m.sa = '0; m.fs = '0; m.c_out = 1'b0; m.k = '0; m.pc_off = '0;
    q.push_back('{nm, e, m});
  endtask

  task automatic exp_br(input string nm, input logic cb, input logic [4:0] rt, input logic tk,
                        input logic [63:0] off);
    ctl_t e, m;
    e = '0; m = '1;
    if (cb) begin e.sa = rt; e.b_sel = 1'b1; e.fs = 5'b01000; end
    else begin m.sa = '0; m.b_sel = 1'b0; m.k = '0; m.fs = '0; m.c_out = 1'b0; end
    if (tk) begin e.pc_load = 1'b1; e.pc_off = off; end
    else begin e.pc_inc = 1'b1; m.pc_off = '0; end
    m.da = '0; m.sb = '0; m.addr = '0;
    q.push_back('{nm, e, m});
  endtask

  task automatic feed(input logic [31:0] w, input int dly, input logic [3:0] st,
                      input logic [7:0] ff, output int c0);
    int n;
    n = 0;
    while (!instr_req && n < 200) begin @(negedge clk); n++; end
    if (!instr_req) begin
      total++; bad++;
      $display("FAIL fetch_wait act=req_low exp=req_high");
    end
    c0 = cyc; stat = st; f = ff;
    repeat (dly) @(negedge clk);
    instr = w; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    logic [10:0] rop [5];
    rop = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000, 11'b11001010000};
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[31:21] = rop[$urandom_range(0, 4)];
      1: w[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
      2: w[31:21] = 11'b11111000010;
      3: w[31:21] = 11'b11111000000;
      4: w[31:26] = 6'b000101;
      5: w[31:24] = 8'hB4;
      default: w[31:24] = 8'hB5;
    endcase
    return w;
  endfunction

  initial begin
    int   c0, n;
    logic ok;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; f = '0; stat = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", instr_req, 0);
    chk("rst_wreg", W_reg, 0);
    chk("rst_addr", addr, 0);
    chk("rst_status", {halted, illegal}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("fetch_after_rst", instr_req, 1);

    // Reset landing in the EXEC cycle of an ADD
    feed(32'h8B020023, 0, 4'h0, 8'h00, c0);
    @(posedge clk); #1;
    chk("exec_wreg", W_reg, 1);
    rst = 1'b0; #1;
    chk("rst_mid_exec", {W_reg, alu_en, pc_inc}, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("restart_fetch", instr_req, 1);
    chk("restart_addr", addr, 0);

    sb_on = 1'b1;
    exp_alu("addi", 5'd1, 5'd31, 5'd0, 5'b01000, 1'b0, 1'b1, 64'd5);
    feed(32'h910017E1, 2, 4'h0, 8'h00, c0);
    n = 0;
    while (!pc_inc && n < 20) begin @(negedge clk); n++; end
    chk("addi_cycles", 64'(cyc - c0 + 1), 5);
    exp_mem("stur", 1'b0, 5'd2, 8'hF8);
    feed(32'hF81F8022, 0, 4'h0, 8'hF8, c0);
    exp_br("cbz_taken", 1'b1, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    feed(32'hB4FFFF83, 0, 4'b0001, 8'h00, c0);
    exp_br("cbz_not", 1'b1, 5'd3, 1'b0, 64'd0);
    feed(32'hB4FFFF83, 1, 4'b0000, 8'h00, c0);
    exp_alu("add", 5'd3, 5'd1, 5'd2, 5'b01000, 1'b0, 1'b0, 64'd0);
    feed(32'h8B020023, 1, 4'h0, 8'h00, c0);
    exp_alu("sub", 5'd5, 5'd6, 5'd7, 5'b01001, 1'b1, 1'b0, 64'd0);
    feed(32'hCB0700C5, 0, 4'h0, 8'h00, c0);
    exp_alu("orr", 5'd0, 5'd1, 5'd2, 5'b00100, 1'b0, 1'b0, 64'd0);
    feed(32'hAA020020, 0, 4'h0, 8'h00, c0);
    exp_alu("eor", 5'd8, 5'd9, 5'd10, 5'b01100, 1'b0, 1'b0, 64'd0);
    feed(32'hCA0A0128, 0, 4'h0, 8'h00, c0);
    exp_alu("and_xzr", 5'd31, 5'd1, 5'd2, 5'b00000, 1'b0, 1'b0, 64'd0);
    feed(32'h8A02003F, 0, 4'h0, 8'h00, c0);
    exp_alu("subi_max", 5'd2, 5'd2, 5'd0, 5'b01001, 1'b1, 1'b1, 64'd4095);
    feed(32'hD13FFC42, 0, 4'h0, 8'h00, c0);
    exp_mem("ldur", 1'b1, 5'd4, 8'h10);
    feed(32'hF8410024, 0, 4'h0, 8'h10, c0);
    exp_mem("ldur_top", 1'b1, 5'd7, 8'hFF);
    feed(32'hF84FF027, 3, 4'h0, 8'hFF, c0);
    exp_br("cbnz_taken", 1'b1, 5'd9, 1'b1, 64'd4);
    feed(32'hB5000029, 0, 4'b0000, 8'h00, c0);
    exp_br("cbnz_not", 1'b1, 5'd9, 1'b0, 64'd0);
    feed(32'hB5000029, 0, 4'b1111, 8'h00, c0);
    exp_br("b_back", 1'b0, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    feed(32'h17FFFFFF, 0, 4'h0, 8'h00, c0);
    exp_br("b_fwd", 1'b0, 5'd0, 1'b1, 64'd12);
    feed(32'h14000003, 0, 4'h0, 8'h00, c0);
    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("sb_drain", 64'(q.size()), 0);
    sb_on = 1'b0;

    repeat (1000) feed(rnd_instr(), $urandom_range(0, 2), 4'($urandom), 8'($urandom), c0);
    repeat (6) @(negedge clk);
    chk("rand_no_halt", {halted, illegal}, 0);

    rst_pulse();
    feed(32'hFFFF_FFFF, 0, 4'h0, 8'h00, c0);
    @(negedge clk);
    chk("hlt_status", {halted, illegal}, 2'b10);

    rst_pulse();
    chk("rst_clears_halt", {halted, illegal}, 0);
    feed(32'h0000_0000, 0, 4'h0, 8'h00, c0);
    @(negedge clk);
    chk("ill_status", {halted, illegal}, 2'b11);
    instr = 32'h8B020023; instr_valid = 1'b1; ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (instr_req | W_reg | W_ram | B_en | alu_en | D_en | pc_inc | pc_load) ok = 1'b0;
    end
    instr_valid = 1'b0;
    chk("halt_quiet", ok, 1);
    chk("halt_sticky", {halted, illegal}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
